// File: rtl/param_test_mem_responder.sv
// param_test_mem_responder: fixed-latency val/rdy memory responder, one request in flight
module param_test_mem_responder #(
  parameter int LATENCY = 2,
  parameter int NWORDS  = 256,
  parameter int IDXBITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [66:0] memreq_msg,
  input  logic        memreq_val,
  output logic        memreq_rdy,
  output logic [34:0] memresp_msg,
  output logic        memresp_val,
  output logic        err_oob
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t             state, state_nxt;
  logic [3:0]         cnt, cnt_nxt;
  logic [66:0]        req;
  logic [31:0]        mem [NWORDS];
  logic               rw, accept, oob, req_oob;
  logic [31:0]        addr, wdata, word, lanes, rdata;
  logic [1:0]         len, off;
  logic [3:0]         nmask, bmask;
  logic [IDXBITS-1:0] idx;
  assign {rw, addr, len, wdata} = req;
  assign off     = addr[1:0];
  assign idx     = addr[IDXBITS+1:2];
  assign oob     = (addr >> (IDXBITS + 2)) != 32'd0;
  assign req_oob = (memreq_msg[65:34] >> (IDXBITS + 2)) != 32'd0;
  assign nmask   = len == 2'd0 ? 4'hf : len == 2'd1 ? 4'h1 : len == 2'd2 ? 4'h3 : 4'h7;
  // lanes shifted past byte 3 fall off the 4-bit mask, so nothing spills into the next word
  assign bmask   = nmask << off;
  assign lanes   = {{8{bmask[3]}}, {8{bmask[2]}}, {8{bmask[1]}}, {8{bmask[0]}}};
  assign word    = mem[idx];
  assign rdata   = (rw || oob) ? 32'd0 : (word & lanes) >> {off, 3'b000};
  assign memreq_rdy  = state == IDLE || state == RESP;
  assign memresp_val = state == RESP;
  assign memresp_msg = memresp_val ? {rw, len, rdata} : 35'd0;
  assign accept      = memreq_val && memreq_rdy;
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (accept) begin
      state_nxt = LATENCY == 1 ? RESP : WAIT;
      cnt_nxt   = 4'(LATENCY - 1);
    end else if (state == RESP) state_nxt = IDLE;
    else if (state == WAIT) begin
      cnt_nxt   = cnt - 4'd1;
      state_nxt = cnt == 4'd1 ? RESP : WAIT;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      req     <= 67'd0;
      err_oob <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) req <= memreq_msg;
      if (accept && req_oob) err_oob <= 1'b1;
    end
  // an async reset forces IDLE, so an in-flight write can never commit here
  always_ff @(posedge clk)
    if (state == RESP && rw && !oob) mem[idx] <= (word & ~lanes) | ((wdata << {off, 3'b000}) & lanes);
endmodule

// File: tb/tb_param_test_mem_responder.sv
// tb_param_test_mem_responder: three responders (LATENCY 2, 1, 4) checked against a byte-level model
module tb_param_test_mem_responder;
  localparam int NW = 256;
  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  logic        clk = 1'b0, reset = 1'b1;
  logic [66:0] msg [3];
  logic [34:0] rm [3];
  logic [2:0]  val, rdy, rv, eo;
  logic [31:0] mm [3][NW];
  logic [2:0]  has, errm;
  logic [66:0] preq [3];
  int          due [3];
  int          errors = 0, checks = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  param_test_mem_responder #(.LATENCY(2)) u0 (.clk(clk), .reset(reset), .memreq_msg(msg[0]), .memreq_val(val[0]),
    .memreq_rdy(rdy[0]), .memresp_msg(rm[0]), .memresp_val(rv[0]), .err_oob(eo[0]));
  param_test_mem_responder #(.LATENCY(1)) u1 (.clk(clk), .reset(reset), .memreq_msg(msg[1]), .memreq_val(val[1]),
    .memreq_rdy(rdy[1]), .memresp_msg(rm[1]), .memresp_val(rv[1]), .err_oob(eo[1]));
  param_test_mem_responder #(.LATENCY(4)) u2 (.clk(clk), .reset(reset), .memreq_msg(msg[2]), .memreq_val(val[2]),
    .memreq_rdy(rdy[2]), .memresp_msg(rm[2]), .memresp_val(rv[2]), .err_oob(eo[2]));

  function automatic int lat(input int i);
    return i == 0 ? 2 : i == 1 ? 1 : 4;
  endfunction

  function automatic logic [66:0] mk(input logic rw, input logic [31:0] a, input logic [1:0] l, input logic [31:0] d);
    return {rw, a, l, d};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // byte-by-byte reference: walks the requested bytes, drops lanes past byte 3
  task automatic model(input int i, input logic [66:0] m, output logic [31:0] d);
    logic [31:0] a;
    int n, off, idx;
    a   = m[65:34];
    n   = m[33:32] == 2'd0 ? 4 : int'(m[33:32]);
    off = int'(a % 4);
    d   = 32'd0;
    if (a >= 32'(NW * 4)) return;
    idx = int'(a / 4);
    for (int k = 0; k < n; k++)
      if (off + k < 4) begin
        if (m[66]) mm[i][idx][8*(off+k) +: 8] = m[8*k +: 8];
        else d[8*k +: 8] = mm[i][idx][8*(off+k) +: 8];
      end
  endtask

  always @(negedge clk) begin : mon
    logic [31:0] d;
    for (int i = 0; i < 3; i++) begin
      if (!reset) begin
        has[i]  = 1'b0;
        errm[i] = 1'b0;
        chk("rst_resp_val", rv[i], 0);
        chk("rst_err_oob", eo[i], 0);
      end else begin
        chk($sformatf("resp_val%0d", i), rv[i], has[i] && due[i] == cyc);
        if (has[i] && due[i] == cyc) begin
          model(i, preq[i], d);
          chk($sformatf("resp_msg%0d", i), rm[i], {preq[i][66], preq[i][33:32], d});
          has[i] = 1'b0;
        end
        chk($sformatf("err_oob%0d", i), eo[i], errm[i]);
        if (val[i] && rdy[i]) begin
          chk("one_outstanding", has[i], 0);
          has[i]  = 1'b1;
          due[i]  = cyc + lat(i);
          preq[i] = msg[i];
          if (msg[i][65:34] >= 32'(NW * 4)) errm[i] = 1'b1;
        end
      end
    end
  end

  task automatic issue(input int i, input logic [66:0] m, output int stalls);
    msg[i] = m;
    val[i] = 1'b1;
    stalls = 0;
    for (int t = 0; t <= 40; t++) begin
      @(negedge clk);
      if (rdy[i]) break;
      stalls++;
    end
    if (!rdy[i]) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout inst %0d", i);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(input int i, output logic [31:0] d);
    bit got;
    got = 1'b0;
    d   = 32'hx;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (rv[i]) begin
        got = 1'b1;
        d   = rm[i][31:0];
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout inst %0d", i);
    end
  endtask

  initial begin
    int st, tot;
    logic [31:0] d, old, a;
    vec_t tbl [12];
    val = 3'b000;
    for (int i = 0; i < 3; i++) msg[i] = 67'd0;
    tbl[0]  = '{1'b1, 32'h10,   2'd0, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b0, 32'h10,   2'd0, 32'h0,        32'hDEADBEEF};
    tbl[2]  = '{1'b1, 32'h13,   2'd1, 32'h000000A5, 32'h0};
    tbl[3]  = '{1'b0, 32'h10,   2'd0, 32'h0,        32'hA5ADBEEF};
    tbl[4]  = '{1'b0, 32'h12,   2'd2, 32'h0,        32'h0000A5AD};
    tbl[5]  = '{1'b0, 32'h13,   2'd3, 32'h0,        32'h000000A5};
    tbl[6]  = '{1'b0, 32'h11,   2'd1, 32'h0,        32'h000000BE};
    tbl[7]  = '{1'b1, 32'h1011, 2'd2, 32'h00001234, 32'h0};
    tbl[8]  = '{1'b0, 32'h1000, 2'd0, 32'h0,        32'h0};
    tbl[9]  = '{1'b0, 32'h10,   2'd0, 32'h0,        32'hA5ADBEEF};
    tbl[10] = '{1'b1, 32'h15,   2'd3, 32'h00C0FFEE, 32'h0};
    tbl[11] = '{1'b0, 32'h16,   2'd2, 32'h0,        32'h0000C0FF};
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1 chk("rdy_after_reset", rdy, 3'b111);
    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < NW; w++) issue(i, mk(1'b1, 32'(w * 4), 2'd0, $urandom), st);
      val[i] = 1'b0;
      repeat (6) @(posedge clk);
      #1;
    end
    issue(0, mk(1'b1, 32'h10, 2'd0, 32'hDEADBEEF), st);
    issue(0, mk(1'b0, 32'h10, 2'd0, 32'h0), st);
    val[0] = 1'b0;
    chk("read_accepted_in_resp", st, 1);
    wait_resp(0, d);
    chk("raw_data", d, 32'hDEADBEEF);
    for (int k = 0; k < 12; k++) begin
      issue(0, mk(tbl[k].rw, tbl[k].addr, tbl[k].len, tbl[k].data), st);
      val[0] = 1'b0;
      wait_resp(0, d);
      chk($sformatf("tbl%0d", k), d, tbl[k].exp);
    end
    chk("err_oob_sticky", eo[0], 1);
    tot = 0;
    for (int k = 0; k < 4; k++) begin
      issue(1, mk(1'b0, 32'(k * 4), 2'd0, 32'h0), st);
      tot += st;
    end
    val[1] = 1'b0;
    chk("l1_no_stalls", tot, 0);
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 150; n++) begin
        a = $urandom_range(0, 9) == 0 ? ($urandom | 32'h400) : 32'($urandom_range(0, 1023));
        issue(i, mk(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), $urandom), st);
        if ($urandom_range(0, 2) == 0) begin
          val[i] = 1'b0;
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
      end
      val[i] = 1'b0;
      repeat (8) @(posedge clk);
      #1;
    end
    chk("err_before_reset", eo[0], 1);
    old = mm[2][8];
    issue(2, mk(1'b1, 32'h20, 2'd0, 32'hCAFEF00D), st);
    val[2] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("rst_async_val", rv, 0);
    chk("rst_async_err", eo, 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1 chk("rdy_release", rdy, 3'b111);
    @(posedge clk);
    #1;
    issue(2, mk(1'b0, 32'h20, 2'd0, 32'h0), st);
    val[2] = 1'b0;
    wait_resp(2, d);
    chk("dropped_write", d, old);
    repeat (6) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
